issue_stage: RTL and testbench

- Producer side of the decoupled instruction channel that feeds the execution units: the sending end of the `decoded` handshake that the ALU consumes.
- Accepts decoded RV32I instructions from the decoder and reads operands from the register file, forwarding from the writeback bus.
- Tracks outstanding destination registers in a scoreboard, stalls on RAW/WAW hazards, and presents one registered instruction per cycle to exec.
- Sits between decode and exec; flush discards the not-yet-issued instruction.

---
 rtl/issue_stage_if.sv | 39 +++
 rtl/issue_stage.sv | 189 ++++++++++++++++++
 tb/tb_issue_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_stage_if.sv
// -----------------------------------------------------------------------------
// issue_stage_if
//   Decoupled "decoded" instruction channel from the issue stage to the
//   execution units. The sender (master) presents a registered instruction with
//   its operands and holds it until the receiver (slave) raises ready.
//
//   Signals
//     valid    : instruction presented (master -> slave)
//     ready    : receiver accepts this cycle (slave -> master)
//     op       : instr opcode[6:2]
//     rd       : destination register index
//     funct3   : funct3 field
//     imm      : sign-extended immediate
//     rs1_val  : source operand 1
//     rs2_val  : source operand 2
// -----------------------------------------------------------------------------
interface issue_stage_if #(
    parameter int XLEN = 32,
    parameter int RW   = 5
);
    logic            valid;
    logic            ready;
    logic [4:0]      op;
    logic [RW-1:0]   rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    modport master (
        output valid, op, rd, funct3, imm, rs1_val, rs2_val,
        input  ready
    );

    modport slave (
        input  valid, op, rd, funct3, imm, rs1_val, rs2_val,
        output ready
    );
endinterface

// File: rtl/issue_stage.sv
// -----------------------------------------------------------------------------
// issue_stage
//   Accepts decoded RV32I instructions, reads operands from the register file
//   (forwarding from the writeback bus), tracks outstanding destinations in a
//   scoreboard, stalls on RAW/WAW hazards and presents one registered
//   instruction per cycle on the decoded channel to exec.
//
//   Ports
//     clk, rst            : clock; asynchronous active-low reset
//     flush               : drop the buffered (not yet handed over) instruction
//     in_*                : decoder side, in_valid/in_ready handshake
//     rf_rs*_idx/_val     : combinational register file read ports
//     wb_valid/_rd_idx/_rd_val : writeback bus (regfile writes at this edge)
//     out                 : decoded channel to exec (master side)
//     stall_cycles        : saturating count of cycles with in_valid && !in_ready
// -----------------------------------------------------------------------------
module issue_stage #(
    parameter int  XLEN = 32,
    parameter int  NREG = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [RW-1:0]    in_rd,
    input  logic [RW-1:0]    in_rs1,
    input  logic [RW-1:0]    in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_uses_rs1,
    input  logic             in_uses_rs2,

    output logic [RW-1:0]    rf_rs1_idx,
    input  logic [XLEN-1:0]  rf_rs1_val,
    output logic [RW-1:0]    rf_rs2_idx,
    input  logic [XLEN-1:0]  rf_rs2_val,

    input  logic             wb_valid,
    input  logic [RW-1:0]    wb_rd_idx,
    input  logic [XLEN-1:0]  wb_rd_val,

    issue_stage_if.master    out,

    output logic [31:0]      stall_cycles
);

    // Output register (single entry)
    logic            out_valid_reg;
    logic [4:0]      out_op_reg;
    logic [RW-1:0]   out_rd_reg;
    logic [2:0]      out_funct3_reg;
    logic [XLEN-1:0] out_imm_reg;
    logic [XLEN-1:0] out_rs1_val_reg;
    logic [XLEN-1:0] out_rs2_val_reg;

    // Scoreboard: one bit per register, set when an instruction is handed to
    // exec and cleared by its writeback.
    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;

    logic [31:0]     stall_cycles_reg;

    logic            slot_free;
    logic            out_fire;
    logic            accept;
    logic            hazard;
    logic [NREG-1:0] busy_vec;
    logic [XLEN-1:0] rs1_operand;
    logic [XLEN-1:0] rs2_operand;

    assign out.valid    = out_valid_reg;
    assign out.op       = out_op_reg;
    assign out.rd       = out_rd_reg;
    assign out.funct3   = out_funct3_reg;
    assign out.imm      = out_imm_reg;
    assign out.rs1_val  = out_rs1_val_reg;
    assign out.rs2_val  = out_rs2_val_reg;
    assign stall_cycles = stall_cycles_reg;

    assign rf_rs1_idx = in_rs1;
    assign rf_rs2_idx = in_rs2;

    assign slot_free = !out_valid_reg || out.ready;
    assign out_fire  = out_valid_reg && out.ready;

    // A register is busy when an issued producer has not written back yet (a
    // writeback landing this cycle counts as done, the value is forwarded), or
    // when the producer is still sitting in the output register. x0 never is.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_vec[gi] = (gi != 0) &&
                ((pending_reg[gi] && !(wb_valid && wb_rd_idx == RW'(gi))) ||
                 (out_valid_reg && out_rd_reg == RW'(gi)));
        end
    endgenerate

    // The busy(in_rd) term blocks a second write to a register still in flight.
    assign hazard = (in_uses_rs1 && busy_vec[in_rs1]) ||
                    (in_uses_rs2 && busy_vec[in_rs2]) ||
                    busy_vec[in_rd];

    assign in_ready = rst && !flush && slot_free && !hazard;
    assign accept   = in_valid && in_ready;

    function automatic logic [XLEN-1:0] sel_operand(
        input logic [RW-1:0]   idx,
        input logic [XLEN-1:0] rf_val,
        input logic            wbv,
        input logic [RW-1:0]   wbi,
        input logic [XLEN-1:0] wbd
    );
        logic [XLEN-1:0] result;
        if (idx == '0) begin
            result = '0;
        end else if (wbv && wbi == idx) begin
            result = wbd;
        end else begin
            result = rf_val;
        end
        return result;
    endfunction

    assign rs1_operand = sel_operand(in_rs1, rf_rs1_val, wb_valid, wb_rd_idx, wb_rd_val);
    assign rs2_operand = sel_operand(in_rs2, rf_rs2_val, wb_valid, wb_rd_idx, wb_rd_val);

    // Set is applied after clear so a same-index set/clear leaves the bit set.
    // The handshake sets pending even under flush: flush only kills entries
    // exec has not taken.
    always_comb begin
        pending_next = pending_reg;
        if (wb_valid) begin
            pending_next[wb_rd_idx] = 1'b0;
        end
        if (out_fire) begin
            pending_next[out_rd_reg] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg    <= 1'b0;
            out_op_reg       <= '0;
            out_rd_reg       <= '0;
            out_funct3_reg   <= '0;
            out_imm_reg      <= '0;
            out_rs1_val_reg  <= '0;
            out_rs2_val_reg  <= '0;
            pending_reg      <= '0;
            stall_cycles_reg <= '0;
        end else begin
            pending_reg <= pending_next;

            // accept implies !flush and a free slot, so the held fields of a
            // stalled handshake are never overwritten.
            if (accept) begin
                out_valid_reg   <= 1'b1;
                out_op_reg      <= in_op;
                out_rd_reg      <= in_rd;
                out_funct3_reg  <= in_funct3;
                out_imm_reg     <= in_imm;
                out_rs1_val_reg <= rs1_operand;
                out_rs2_val_reg <= rs2_operand;
            end else if (flush || out_fire) begin
                out_valid_reg <= 1'b0;
            end

            if (in_valid && !in_ready && !flush && stall_cycles_reg != '1) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

`ifndef SYNTHESIS
    // Decoupled rule: a presented instruction stays put until taken or flushed.
    property p_out_hold;
        @(posedge clk) disable iff (!rst)
        (out_valid_reg && !out.ready && !flush) |=>
            (out_valid_reg && $stable({out_op_reg, out_rd_reg, out_funct3_reg,
                                       out_imm_reg, out_rs1_val_reg, out_rs2_val_reg}));
    endproperty
    a_out_hold: assert property (p_out_hold);
`endif

endmodule

// File: tb/tb_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_issue_stage
//   Self-checking bench for issue_stage: a cycle script table, hand-written
//   reset/backpressure/flush sequences and a randomized run against a
//   queue-based reference model of the issue rules.
// -----------------------------------------------------------------------------
module tb_issue_stage;

    localparam logic [4:0] OPI = 5'b00100;
    localparam logic [4:0] OPR = 5'b01100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        in_uses_rs1, in_uses_rs2;
    logic [4:0]  rf_rs1_idx, rf_rs2_idx;
    logic [31:0] rf_rs1_val, rf_rs2_val;
    logic        wb_valid;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_rd_val;
    logic [31:0] stall_cycles;

    // Bench-owned register file; rf_ones forces all-ones read data.
    logic [31:0] regs [32];
    logic        rf_ones;
    assign rf_rs1_val = rf_ones ? 32'hFFFF_FFFF : regs[rf_rs1_idx];
    assign rf_rs2_val = rf_ones ? 32'hFFFF_FFFF : regs[rf_rs2_idx];

    issue_stage_if #(.XLEN(32), .RW(5)) dec_if ();

    issue_stage #(.XLEN(32), .NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_funct3    (in_funct3),
        .in_imm       (in_imm),
        .in_uses_rs1  (in_uses_rs1),
        .in_uses_rs2  (in_uses_rs2),
        .rf_rs1_idx   (rf_rs1_idx),
        .rf_rs1_val   (rf_rs1_val),
        .rf_rs2_idx   (rf_rs2_idx),
        .rf_rs2_val   (rf_rs2_val),
        .wb_valid     (wb_valid),
        .wb_rd_idx    (wb_rd_idx),
        .wb_rd_val    (wb_rd_val),
        .out          (dec_if),
        .stall_cycles (stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic init_regs();
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h1000 + 32'(i);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_imm = '0; in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0;
        flush = 1'b0; wb_valid = 1'b0; wb_rd_idx = '0; wb_rd_val = '0;
        dec_if.ready = 1'b0; rf_ones = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm,
                         input logic u1, input logic u2, input logic ord);
        idle_inputs();
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_uses_rs1 = u1; in_uses_rs2 = u2; dec_if.ready = ord;
    endtask

    // Advance one clock; the regfile takes the writeback at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (wb_valid && wb_rd_idx != 5'd0) regs[wb_rd_idx] = wb_rd_val;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        init_regs();
    endtask

    // ------------------------------------------------------------ cycle script
    typedef struct {
        logic        iv;
        logic [4:0]  op, rd, rs1, rs2;
        logic [31:0] imm;
        logic        u1, u2, ord, wbv;
        logic [4:0]  wbi;
        logic [31:0] wbd;
        logic        ones;
        logic        x_ready, x_ov;
        logic [4:0]  x_rd;
        logic [31:0] x_imm;
        logic        chk_ops;
        logic [31:0] x_rs1, x_rs2, x_stall;
    } vec_t;

    function automatic vec_t mk(
        input logic iv, input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [31:0] imm, input logic u1, input logic u2,
        input logic ord, input logic wbv, input logic [4:0] wbi, input logic [31:0] wbd,
        input logic ones, input logic xr, input logic xov, input logic [4:0] xrd,
        input logic [31:0] ximm, input logic cops, input logic [31:0] xs1,
        input logic [31:0] xs2, input logic [31:0] xst);
        vec_t v;
        v.iv = iv; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.u1 = u1; v.u2 = u2; v.ord = ord; v.wbv = wbv; v.wbi = wbi; v.wbd = wbd;
        v.ones = ones; v.x_ready = xr; v.x_ov = xov; v.x_rd = xrd; v.x_imm = ximm;
        v.chk_ops = cops; v.x_rs1 = xs1; v.x_rs2 = xs2; v.x_stall = xst;
        return v;
    endfunction

    vec_t vecs [11];

    // ------------------------------------------------------------ reference model
    int          inflight_q [$];   // registers handed to exec, awaiting writeback
    logic        m_bv;
    logic [4:0]  m_op, m_rd;
    logic [2:0]  m_f3;
    logic [31:0] m_imm, m_rs1, m_rs2;
    logic        m_u1, m_u2;
    int unsigned m_stall;

    function automatic bit in_flight(input logic [4:0] r);
        foreach (inflight_q[i]) if (inflight_q[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 5'd0) && (in_flight(r) || (m_bv && m_rd == r));
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_valid && wb_rd_idx == r) return wb_rd_val;
        return regs[r];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic exp_ready;
        logic fire;
        int   k;

        // --------------------------------------------------- reset state
        idle_inputs();
        init_regs();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("reset out_valid", 32'(dec_if.valid), 32'd0);
        chk("reset out_rd", 32'(dec_if.rd), 32'd0);
        chk("reset out_imm", dec_if.imm, 32'd0);
        chk("reset out_rs1_val", dec_if.rs1_val, 32'd0);
        chk("reset stall_cycles", stall_cycles, 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        $display("reset state checked");
        do_reset();

        // --------------------------------------------------- table
        //          iv op  rd rs1 rs2 imm u1 u2 ord wbv wbi wbd     1s  rdy ov rd imm ops rs1      rs2      stall
        vecs[0]  = mk(1, OPI, 1, 0, 0, 5,  1, 0, 1, 0, 0, 0,        0,  1, 1, 1, 5,  1, 0,       0,       0);
        vecs[1]  = mk(1, OPI, 2, 0, 0, 7,  1, 0, 1, 0, 0, 0,        0,  1, 1, 2, 7,  1, 0,       0,       0);
        vecs[2]  = mk(1, OPR, 4, 1, 2, 0,  1, 1, 1, 0, 0, 0,        0,  0, 0, 0, 0,  0, 0,       0,       1);
        vecs[3]  = mk(1, OPR, 4, 1, 2, 0,  1, 1, 1, 1, 1, 32'h11,   0,  0, 0, 0, 0,  0, 0,       0,       2);
        vecs[4]  = mk(1, OPR, 4, 1, 2, 0,  1, 1, 1, 1, 2, 32'h22,   0,  1, 1, 4, 0,  1, 32'h11,  32'h22,  2);
        vecs[5]  = mk(1, OPI, 0, 0, 0, 1,  1, 0, 1, 0, 0, 0,        0,  1, 1, 0, 1,  1, 0,       0,       2);
        vecs[6]  = mk(1, OPR, 7, 0, 0, 0,  1, 1, 1, 0, 0, 0,        1,  1, 1, 7, 0,  1, 0,       0,       2);
        vecs[7]  = mk(0, 0,   0, 0, 0, 0,  0, 0, 1, 0, 0, 0,        0,  1, 0, 0, 0,  0, 0,       0,       2);
        vecs[8]  = mk(1, OPI, 4, 0, 0, 9,  1, 0, 1, 0, 0, 0,        0,  0, 0, 0, 0,  0, 0,       0,       3);
        vecs[9]  = mk(1, OPI, 4, 0, 0, 9,  1, 0, 1, 1, 4, 32'h44,   0,  1, 1, 4, 9,  1, 0,       0,       3);
        vecs[10] = mk(0, 0,   0, 0, 0, 0,  0, 0, 1, 0, 0, 0,        0,  1, 0, 0, 0,  0, 0,       0,       3);

        for (int i = 0; i < 11; i++) begin
            v = vecs[i];
            idle_inputs();
            in_valid = v.iv; in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
            in_imm = v.imm; in_uses_rs1 = v.u1; in_uses_rs2 = v.u2; dec_if.ready = v.ord;
            wb_valid = v.wbv; wb_rd_idx = v.wbi; wb_rd_val = v.wbd; rf_ones = v.ones;
            #1;
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(v.x_ready));
            chk($sformatf("vec%0d rf_rs1_idx", i), 32'(rf_rs1_idx), 32'(v.rs1));
            tick();
            chk($sformatf("vec%0d out_valid", i), 32'(dec_if.valid), 32'(v.x_ov));
            chk($sformatf("vec%0d stall_cycles", i), stall_cycles, v.x_stall);
            if (v.x_ov) begin
                chk($sformatf("vec%0d out_rd", i), 32'(dec_if.rd), 32'(v.x_rd));
                chk($sformatf("vec%0d out_imm", i), dec_if.imm, v.x_imm);
                chk($sformatf("vec%0d out_op", i), 32'(dec_if.op), 32'(v.op));
            end
            if (v.chk_ops) begin
                chk($sformatf("vec%0d out_rs1_val", i), dec_if.rs1_val, v.x_rs1);
                chk($sformatf("vec%0d out_rs2_val", i), dec_if.rs2_val, v.x_rs2);
            end
            $display("vec %0d: in_ready=%0b out_valid=%0b out_rd=%0d stall=%0d",
                     i, v.x_ready, dec_if.valid, dec_if.rd, stall_cycles);
        end

        // --------------------------------------------------- backpressure
        do_reset();
        drive(OPI, 5'd6, 5'd0, 5'd0, 32'h66, 1'b1, 1'b0, 1'b0);
        #1 chk("bp first in_ready", 32'(in_ready), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(OPI, 5'd8, 5'd0, 5'd0, 32'h88, 1'b1, 1'b0, 1'b0);
            #1 chk("bp held in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp held out_valid", 32'(dec_if.valid), 32'd1);
            chk("bp held out_rd", 32'(dec_if.rd), 32'd6);
            chk("bp held out_imm", dec_if.imm, 32'h66);
            chk("bp stall_cycles", stall_cycles, 32'(i + 1));
            $display("backpressure cycle %0d: out_rd=%0d stall=%0d", i, dec_if.rd, stall_cycles);
        end
        drive(OPI, 5'd8, 5'd0, 5'd0, 32'h88, 1'b1, 1'b0, 1'b1);
        #1 chk("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp next out_rd", 32'(dec_if.rd), 32'd8);
        chk("bp next out_imm", dec_if.imm, 32'h88);
        drive(OPR, 5'd9, 5'd6, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        #1 chk("bp x6 pending in_ready", 32'(in_ready), 32'd0);
        $display("backpressure released: out_rd=%0d", dec_if.rd);

        // --------------------------------------------------- flush
        do_reset();
        drive(OPI, 5'd6, 5'd0, 5'd0, 32'h6, 1'b1, 1'b0, 1'b0);
        tick();
        chk("flush buffered out_valid", 32'(dec_if.valid), 32'd1);
        drive(OPI, 5'd13, 5'd0, 5'd0, 32'hD, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1 chk("flush cycle in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("flush out_valid", 32'(dec_if.valid), 32'd0);
        chk("flush no stall count", stall_cycles, 32'd0);
        drive(OPR, 5'd9, 5'd6, 5'd6, 32'd0, 1'b1, 1'b1, 1'b0);
        #1 chk("flushed x6 not pending", 32'(in_ready), 32'd1);
        tick();
        chk("flush read x6 rd", 32'(dec_if.rd), 32'd9);
        chk("flush read x6 rs1", dec_if.rs1_val, 32'h1006);
        idle_inputs();
        flush = 1'b1;
        dec_if.ready = 1'b1;
        tick();
        chk("flush+ready out_valid", 32'(dec_if.valid), 32'd0);
        drive(OPI, 5'd10, 5'd9, 5'd0, 32'd1, 1'b1, 1'b0, 1'b1);
        #1 chk("flush+ready x9 pending", 32'(in_ready), 32'd0);
        $display("flush sequence done");

        // --------------------------------------------------- reset mid-stream
        do_reset();
        drive(OPI, 5'd5, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(OPI, 5'd11, 5'd0, 5'd0, 32'hB, 1'b1, 1'b0, 1'b1);
        tick();
        drive(OPR, 5'd12, 5'd5, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        #1 chk("mid x5 pending in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("mid stall before reset", stall_cycles, 32'd1);
        chk("mid out_valid before reset", 32'(dec_if.valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid async out_valid", 32'(dec_if.valid), 32'd0);
        chk("mid async out_rd", 32'(dec_if.rd), 32'd0);
        chk("mid async stall", stall_cycles, 32'd0);
        chk("mid async in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("mid held in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1 chk("mid release in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("mid after out_rd", 32'(dec_if.rd), 32'd12);
        chk("mid after rs1", dec_if.rs1_val, 32'h1005);
        $display("reset mid-stream done");

        // --------------------------------------------------- randomized run
        do_reset();
        inflight_q.delete();
        m_bv = 1'b0; m_op = '0; m_rd = '0; m_f3 = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0;
        m_u1 = 1'b0; m_u2 = 1'b0; m_stall = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            idle_inputs();
            in_valid    = ($urandom_range(0, 3) != 0);
            in_op       = 5'($urandom);
            in_rd       = 5'($urandom_range(0, 7));
            in_rs1      = 5'($urandom_range(0, 7));
            in_rs2      = 5'($urandom_range(0, 7));
            in_funct3   = 3'($urandom);
            in_imm      = $urandom;
            in_uses_rs1 = 1'($urandom);
            in_uses_rs2 = 1'($urandom);
            dec_if.ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            if (inflight_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, inflight_q.size() - 1));
                wb_valid  = 1'b1;
                wb_rd_idx = 5'(inflight_q[k]);
                wb_rd_val = $urandom;
                inflight_q.delete(k);
            end
            #1;
            exp_ready = !flush && (!m_bv || dec_if.ready) &&
                        !((in_uses_rs1 && m_busy(in_rs1)) || (in_uses_rs2 && m_busy(in_rs2)) ||
                          m_busy(in_rd));
            chk("rand in_ready", 32'(in_ready), 32'(exp_ready));
            chk("rand out_valid", 32'(dec_if.valid), 32'(m_bv));
            chk("rand stall_cycles", stall_cycles, m_stall);
            if (m_bv) begin
                chk("rand out_op", 32'(dec_if.op), 32'(m_op));
                chk("rand out_rd", 32'(dec_if.rd), 32'(m_rd));
                chk("rand out_funct3", 32'(dec_if.funct3), 32'(m_f3));
                chk("rand out_imm", dec_if.imm, m_imm);
                if (m_u1) chk("rand out_rs1_val", dec_if.rs1_val, m_rs1);
                if (m_u2) chk("rand out_rs2_val", dec_if.rs2_val, m_rs2);
            end

            fire = m_bv && dec_if.ready;
            if (fire && m_rd != 5'd0) inflight_q.push_back(int'(m_rd));
            if (in_valid && !exp_ready && !flush) m_stall++;
            if (in_valid && exp_ready) begin
                m_bv = 1'b1; m_op = in_op; m_rd = in_rd; m_f3 = in_funct3; m_imm = in_imm;
                m_u1 = in_uses_rs1; m_u2 = in_uses_rs2;
                m_rs1 = m_operand(in_rs1);
                m_rs2 = m_operand(in_rs2);
                $display("rand %0d: issue rd=x%0d rs1=x%0d rs2=x%0d inflight=%0d",
                         cyc, in_rd, in_rs1, in_rs2, inflight_q.size());
            end else if (fire || flush) begin
                m_bv = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
